game_controller: RTL and testbench

GAME_CONTROLLER -- requirements
Module: game_controller

---
 rtl/game_controller.sv | 150 +++++++++++++++
 tb/tb_game_controller.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_controller.sv
// Connect-four style game sequencer: accepts drops, keeps the board and evaluates
// one line direction per cycle after each accepted drop.
module game_controller #(
   parameter int ROWS = 6,
   parameter int COLS = 7
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   drop,
   input  logic [2:0]             column,
   output logic [1:0]             state,
   output logic [1:0]             game_status,
   output logic                   busy,
   output logic                   drop_rejected,
   output logic [2*ROWS*COLS-1:0] board
);

   localparam int HW = $clog2(ROWS + 1);
   localparam int MW = $clog2(ROWS * COLS + 1);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

   typedef enum logic [1:0] {
      GAME_INIT = 2'b00,
      P1_TURN   = 2'b01,
      P2_TURN   = 2'b10,
      END_GAME  = 2'b11
   } phase_t;

   typedef enum logic [1:0] {
      STILL_PLAYING = 2'b00,
      P1_WINS       = 2'b01,
      P2_WINS       = 2'b10,
      TIE           = 2'b11
   } status_t;

   phase_t        st;
   status_t       status;
   logic [HW-1:0] heights [COLS];
   logic [MW-1:0] moves;
   logic [1:0]    dir;
   logic          win_acc;
   logic [RW-1:0] cur_row;
   logic [2:0]    cur_col;
   logic [1:0]    cur_mover;

   logic          in_turn, col_ok, col_full, accept, reject, win_now;
   logic [HW-1:0] sel_height;
   logic [1:0]    mover;
   int            dr, dc, line_len, wr_idx;

   assign state       = st;
   assign game_status = status;

   // Contiguous cells owned by 'who' walking away from (r,c), capped at three.
   function automatic int side_run(input logic [2*ROWS*COLS-1:0] b, input int r, input int c,
                                   input int sr, input int sc, input logic [1:0] who);
      int   n;
      logic run;
      n   = 0;
      run = 1'b1;
      for (int unsigned k = 1; k <= 3; k++) begin
         int rr;
         int cc;
         rr = r + int'(k) * sr;
         cc = c + int'(k) * sc;
         if (run && rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS &&
             b[2*(rr*COLS+cc) +: 2] == who)
            n++;
         else
            run = 1'b0;
      end
      return n;
   endfunction

   always_comb begin
      in_turn    = (st == P1_TURN) || (st == P2_TURN);
      col_ok     = int'(column) < COLS;
      sel_height = col_ok ? heights[column] : '0;
      col_full   = (sel_height == HW'(ROWS));
      accept     = drop && in_turn && !busy && col_ok && !col_full;
      reject     = drop && in_turn && (busy || !col_ok || col_full);
      mover      = (st == P1_TURN) ? 2'b01 : 2'b10;
      wr_idx     = 2 * (int'(sel_height) * COLS + int'(column));
      case (dir)
         2'd0:    begin dr = 0; dc = 1;  end
         2'd1:    begin dr = 1; dc = 0;  end
         2'd2:    begin dr = 1; dc = 1;  end
         default: begin dr = 1; dc = -1; end
      endcase
      line_len = 1 + side_run(board, int'(cur_row), int'(cur_col), dr, dc, cur_mover)
                   + side_run(board, int'(cur_row), int'(cur_col), -dr, -dc, cur_mover);
      win_now  = line_len >= 4;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st            <= GAME_INIT;
         status        <= STILL_PLAYING;
         board         <= '0;
         moves         <= '0;
         busy          <= 1'b0;
         drop_rejected <= 1'b0;
         dir           <= '0;
         win_acc       <= 1'b0;
         cur_row       <= '0;
         cur_col       <= '0;
         cur_mover     <= '0;
         for (int unsigned i = 0; i < COLS; i++) heights[i] <= '0;
      end else begin
         drop_rejected <= reject;
         if (start && (st == GAME_INIT || st == END_GAME)) begin
            st     <= P1_TURN;
            status <= STILL_PLAYING;
            board  <= '0;
            moves  <= '0;
            busy   <= 1'b0;
            for (int unsigned i = 0; i < COLS; i++) heights[i] <= '0;
         end else if (accept) begin
            board[wr_idx +: 2] <= mover;
            heights[column]    <= sel_height + HW'(1);
            moves              <= moves + MW'(1);
            busy               <= 1'b1;
            dir                <= '0;
            win_acc            <= 1'b0;
            cur_row            <= RW'(sel_height);
            cur_col            <= column;
            cur_mover          <= mover;
         end else if (busy) begin
            // Last direction resolves the move; a win outranks a full board.
            if (dir == 2'd3) begin
               busy <= 1'b0;
               if (win_acc || win_now) begin
                  st     <= END_GAME;
                  status <= (cur_mover == 2'b01) ? P1_WINS : P2_WINS;
               end else if (moves == MW'(ROWS * COLS)) begin
                  st     <= END_GAME;
                  status <= TIE;
               end else begin
                  st <= (st == P1_TURN) ? P2_TURN : P1_TURN;
               end
            end else begin
               dir     <= dir + 2'd1;
               win_acc <= win_acc | win_now;
            end
         end
      end
   end

endmodule

// File: tb/tb_game_controller.sv
// Directed and random games checked against a whole-board reference model.
module tb_game_controller;

   localparam int ROWS = 6;
   localparam int COLS = 7;

   logic                   clk;
   logic                   rst_n;
   logic                   start;
   logic                   drop;
   logic [2:0]             column;
   logic [1:0]             state;
   logic [1:0]             game_status;
   logic                   busy;
   logic                   drop_rejected;
   logic [2*ROWS*COLS-1:0] board;

   int vectors    = 0;
   int miscompares = 0;

   int mb [ROWS][COLS];
   int m_state;
   int m_status;
   int m_moves;

   int tie_seq [42] = '{0,0,2,0,0,1,0,0,1,2,1,1,4,1,1,2,2,3,2,2,3,4,3,3,6,3,3,4,4,5,4,4,
                        5,6,5,6,6,5,6,5,5,6};
   int win_tail [10] = '{6,6,5,6,5,5,5,6,5,6};
   int diag_seq [10] = '{1,0,2,1,2,2,3,3,3,3};

   game_controller #(.ROWS(ROWS), .COLS(COLS)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .drop         (drop),
      .column       (column),
      .state        (state),
      .game_status  (game_status),
      .busy         (busy),
      .drop_rejected(drop_rejected),
      .board        (board)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void m_clear();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) mb[r][c] = 0;
      m_moves  = 0;
      m_status = 0;
   endfunction

   function automatic int m_height(input int c);
      int h = 0;
      for (int r = 0; r < ROWS; r++) if (mb[r][c] != 0) h++;
      return h;
   endfunction

   function automatic bit m_has_line(input int who);
      int ddr [4] = '{0, 1, 1, 1};
      int ddc [4] = '{1, 0, 1, -1};
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            for (int d = 0; d < 4; d++) begin
               bit ok = 1'b1;
               for (int k = 0; k < 4; k++) begin
                  int rr = r + k * ddr[d];
                  int cc = c + k * ddc[d];
                  if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) ok = 1'b0;
                  else if (mb[rr][cc] != who) ok = 1'b0;
               end
               if (ok) return 1'b1;
            end
      return 1'b0;
   endfunction

   function automatic logic [2*ROWS*COLS-1:0] m_vec();
      logic [2*ROWS*COLS-1:0] v = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) v[2*(r*COLS+c) +: 2] = 2'(mb[r][c]);
      return v;
   endfunction

   function automatic void m_resolve(input int mover);
      if (m_has_line(mover)) begin
         m_state  = 3;
         m_status = mover;
      end else if (m_moves == ROWS * COLS) begin
         m_state  = 3;
         m_status = 3;
      end else begin
         m_state = 3 - m_state;
      end
   endfunction

   task automatic check_idle(input string tag);
      chk({tag, "_state"}, state, m_state);
      chk({tag, "_status"}, game_status, m_status);
      chk({tag, "_board"}, board, m_vec());
      chk({tag, "_busy"}, busy, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      m_clear();
      m_state = 0;
      check_idle("rst");
      chk("rst_rej", drop_rejected, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (m_state == 0 || m_state == 3) begin
         m_clear();
         m_state = 1;
      end
      check_idle("start");
   endtask

   task automatic play(input int col);
      bit turn, acc;
      int h, mover;
      turn = (m_state == 1 || m_state == 2);
      h    = (col < COLS) ? m_height(col) : ROWS;
      acc  = turn && col < COLS && h < ROWS;
      @(negedge clk);
      drop   = 1'b1;
      column = 3'(col);
      @(negedge clk);
      drop = 1'b0;
      if (acc) begin
         mover        = m_state;
         mb[h][col]   = mover;
         m_moves++;
         chk("busy_e0", busy, 1);
         chk("board_e0", board, m_vec());
         chk("rej_acc", drop_rejected, 0);
         for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("busy_chk", busy, 1);
            chk("state_hold", state, m_state);
         end
         @(negedge clk);
         m_resolve(mover);
         chk("busy_e4", busy, 0);
         chk("state_e4", state, m_state);
         chk("status_e4", game_status, m_status);
      end else begin
         chk("rej_pulse", drop_rejected, turn);
         check_idle("rej");
         @(negedge clk);
         chk("rej_one", drop_rejected, 0);
      end
   endtask

   initial begin
      int h, mover, col;
      rst_n  = 1'b0;
      start  = 1'b0;
      drop   = 1'b0;
      column = '0;
      m_clear();
      m_state = 0;
      repeat (2) @(posedge clk);
      #1;
      check_idle("por");
      chk("por_rej", drop_rejected, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // first move lands at the bottom of column 3
      play(2);
      do_start();
      play(3);
      chk("cell03", board[7:6], 2'b01);
      chk("first_state", state, 2'b10);
      chk("first_status", game_status, 2'b00);
      do_start();

      // vertical P1 win, then drops are ignored
      do_reset();
      do_start();
      foreach (win_tail[i]) if (i < 7) play(i % 2);
      chk("vwin_state", state, 2'b11);
      chk("vwin_status", game_status, 2'b01);
      play(4);
      play(7);
      do_start();

      // full column, illegal column, drop while busy
      for (int i = 0; i < 6; i++) play(2);
      play(2);
      play(7);
      @(negedge clk);
      drop   = 1'b1;
      column = 3'd4;
      @(negedge clk);
      column = 3'd5;
      h      = m_height(4);
      mover  = m_state;
      mb[h][4] = mover;
      m_moves++;
      chk("bd_busy", busy, 1);
      @(negedge clk);
      drop = 1'b0;
      chk("bd_rej", drop_rejected, 1);
      chk("bd_board", board, m_vec());
      @(negedge clk);
      chk("bd_rej_one", drop_rejected, 0);
      @(negedge clk);
      @(negedge clk);
      m_resolve(mover);
      chk("bd_state", state, m_state);
      chk("bd_busy_e4", busy, 0);

      // P2 up-right diagonal
      do_reset();
      do_start();
      foreach (diag_seq[i]) play(diag_seq[i]);
      chk("diag_state", state, 2'b11);
      chk("diag_status", game_status, 2'b10);

      // full board without a line, then full board won on the last move
      do_start();
      foreach (tie_seq[i]) play(tie_seq[i]);
      chk("tie_state", state, 2'b11);
      chk("tie_status", game_status, 2'b11);
      do_start();
      for (int i = 0; i < 32; i++) play(tie_seq[i]);
      foreach (win_tail[i]) play(win_tail[i]);
      chk("lastwin_state", state, 2'b11);
      chk("lastwin_status", game_status, 2'b10);

      // reset at E2 abandons the check
      do_start();
      @(negedge clk);
      drop   = 1'b1;
      column = 3'd1;
      @(negedge clk);
      drop = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      m_clear();
      m_state = 0;
      check_idle("midrst");
      chk("midrst_rej", drop_rejected, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check_idle("after_rel");
      play(3);

      // random games
      for (int g = 0; g < 8; g++) begin
         do_start();
         for (int n = 0; n < 50 && m_state != 3; n++) begin
            col = ($urandom_range(0, 15) == 0) ? 7 : int'($urandom_range(0, COLS - 1));
            play(col);
            if ($urandom_range(0, 9) == 0) do_start();
         end
         if (m_state == 3) play(int'($urandom_range(0, COLS - 1)));
         else do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
